// File: rtl/dance_cmd_sequencer.sv
// Framed UART command decoder (SYNC, CMD, ARG, CHK) driving wave-generator config and step tick.
// Optional inter-byte timeout is compiled in with `define CMD_TIMEOUT_EN.
module dance_cmd_sequencer #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [7:0]  DEFAULT_DIV    = 8'd63,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [2:0] img_sel,
    output logic [7:0] step_div,
    output logic       gen_en,
    output logic       step_tick,
    output logic       cmd_ack,
    output logic       cmd_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GET_CMD = 3'd1;
    localparam logic [2:0] S_GET_ARG = 3'd2;
    localparam logic [2:0] S_GET_CHK = 3'd3;
    localparam logic [2:0] S_APPLY   = 3'd4;

    localparam logic [7:0] CMD_IMG = 8'h01;
    localparam logic [7:0] CMD_DIV = 8'h02;
    localparam logic [7:0] CMD_EN  = 8'h03;

    logic [2:0] state;
    logic [7:0] cmd_q;
    logic [7:0] arg_q;
    logic [7:0] chk_q;
    logic [7:0] tick_cnt;
    logic       timeout;

    logic apply;
    logic chk_ok;
    logic wr_img;
    logic wr_div;
    logic wr_en;
    logic frame_ok;

    assign apply    = (state == S_APPLY);
    assign chk_ok   = (chk_q == (cmd_q ^ arg_q));
    assign wr_img   = apply && chk_ok && (cmd_q == CMD_IMG);
    assign wr_div   = apply && chk_ok && (cmd_q == CMD_DIV);
    assign wr_en    = apply && chk_ok && (cmd_q == CMD_EN);
    assign frame_ok = wr_img || wr_div || wr_en;

`ifdef CMD_TIMEOUT_EN
    logic [23:0] timer;
    logic        in_frame;

    assign in_frame = (state == S_GET_CMD) || (state == S_GET_ARG) || (state == S_GET_CHK);
    assign timeout  = in_frame && (timer == (TIMEOUT_CYCLES - 24'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= 24'd0;
        end else if (rx_valid || !in_frame || timeout) begin
            timer <= 24'd0;
        end else begin
            timer <= timer + 24'd1;
        end
    end
`else
    logic [23:0] timeout_unused;
    assign timeout_unused = TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
`endif

    // Timeout overrides any byte arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cmd_q <= 8'd0;
            arg_q <= 8'd0;
            chk_q <= 8'd0;
        end else if (timeout) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) state <= S_GET_CMD;
                end
                S_GET_CMD: begin
                    if (rx_valid) begin
                        cmd_q <= rx_data;
                        state <= S_GET_ARG;
                    end
                end
                S_GET_ARG: begin
                    if (rx_valid) begin
                        arg_q <= rx_data;
                        state <= S_GET_CHK;
                    end
                end
                S_GET_CHK: begin
                    if (rx_valid) begin
                        chk_q <= rx_data;
                        state <= S_APPLY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_sel  <= 3'd0;
            step_div <= DEFAULT_DIV;
            gen_en   <= 1'b0;
            cmd_ack  <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            cmd_ack <= frame_ok;
            cmd_err <= (apply && !frame_ok) || timeout;
            if (wr_img) img_sel  <= arg_q[2:0];
            if (wr_div) step_div <= arg_q;
            if (wr_en)  gen_en   <= arg_q[0];
        end
    end

    // A divider write restarts the period from zero, ahead of wrap/increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= 8'd0;
            step_tick <= 1'b0;
        end else if (wr_div || !gen_en) begin
            tick_cnt  <= 8'd0;
            step_tick <= 1'b0;
        end else if (tick_cnt == step_div) begin
            tick_cnt  <= 8'd0;
            step_tick <= 1'b1;
        end else begin
            tick_cnt  <= tick_cnt + 8'd1;
            step_tick <= 1'b0;
        end
    end

endmodule
